// File: rtl/data_mem_pkg.sv
// Package for the latency data memory.
// Holds the FSM state encoding, the default parameter values and the
// even-parity helper shared by the top level and the storage array.
// Optional feature macro: DATA_MEM_PARITY_EN (stored parity per word).
package data_mem_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_LATENCY = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Even parity over a word zero-extended to 64 bits (DATA_W <= 64).
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/data_mem_lat_if.sv
// Bus between the CPU core (master) and the latency data memory (slave).
// Signals: read/write level requests, address, write_data, parity_inj
// from the core; read_data, busy_wait, err, parity_err back to the core.
//
// Handshake: a request is valid when exactly one of read/write is high.
// busy_wait acts as an inverted ready: it rises combinationally in the
// same cycle a valid request is seen in IDLE and stays high until the
// access completes; the cycle it first drops again is the completion
// cycle, in which read_data/err/parity_err are valid. Requests still
// held during that completion cycle are ignored.
interface data_mem_lat_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              parity_inj;
  logic [DATA_W-1:0] read_data;
  logic              busy_wait;
  logic              err;
  logic              parity_err;

  modport master (
    output read, write, address, write_data, parity_inj,
    input  read_data, busy_wait, err, parity_err
  );

  modport slave (
    input  read, write, address, write_data, parity_inj,
    output read_data, busy_wait, err, parity_err
  );
endinterface

// File: rtl/data_mem_array.sv
// Single-port word storage for the latency data memory.
// Ports: clk, rst (async clear of every word), we_i (synchronous write
// enable), addr_i (shared read/write address, must be < DEPTH when used),
// wdata_i, rdata_o (combinational read). With DATA_MEM_PARITY_EN defined
// an extra parity bit per word is stored (wpar_i) and read (rpar_o).
module data_mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
`ifdef DATA_MEM_PARITY_EN
  input  logic              wpar_i,
  output logic              rpar_o,
`endif
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

`ifdef DATA_MEM_PARITY_EN
  // Cleared parity 0 matches the parity of cleared (zero) data.
  logic par_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) par_q[i] <= 1'b0;
    end else if (we_i) begin
      par_q[addr_i] <= wpar_i;
    end
  end

  assign rpar_o = par_q[addr_i];
`endif

endmodule

// File: rtl/data_mem_lat.sv
// Parametrised single-port data memory with configurable access latency
// and a busy_wait stall toward the core.
// Ports: clk, rst (async, active-high), bus (data_mem_lat_if slave:
// read, write, address, write_data, parity_inj in; read_data, busy_wait,
// err, parity_err out), state_o (current FSM state, for observation).
// Optional feature macro: DATA_MEM_PARITY_EN adds a stored even-parity
// bit per word and the parity_err pulse; without it parity_err is 0 and
// parity_inj is ignored.
module data_mem_lat
  import data_mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_lat_if.slave bus,
  output state_e        state_o
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              req_valid;
  logic              req_conflict;
  logic              accept;
  logic              busy;
  logic              mem_we;
  logic              last_cycle;
  logic              oob;
  logic [DATA_W-1:0] arr_rdata;

  assign req_valid    = bus.read ^ bus.write;
  assign req_conflict = bus.read & bus.write;
  assign oob          = {1'b0, addr_q} >= DEPTH_X;
  // The access itself happens on the edge that ends this cycle.
  assign last_cycle   = (state_q == BUSY) && (cnt_q == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = BUSY;
      BUSY:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy   = 1'b0;
    accept = 1'b0;
    mem_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Combinational so the core stalls in the request cycle itself.
        busy   = req_valid & ~rst;
        accept = req_valid & ~rst;
      end
      BUSY: begin
        busy   = 1'b1;
        mem_we = last_cycle & wr_cmd_q & ~oob;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept)                                 cnt_d = CNT_LOAD;
    else if (state_q == BUSY && cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Command latch: later bus changes cannot affect an accepted access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cmd_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      wr_cmd_q <= bus.write;
      addr_q   <= bus.address;
      wdata_q  <= bus.write_data;
    end
  end

  // read_data holds until the next completed read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (last_cycle && !wr_cmd_q) begin
      rdata_q <= oob ? '0 : arr_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= ((state_q == IDLE) && req_conflict) || (last_cycle && oob);
  end

`ifdef DATA_MEM_PARITY_EN
  logic inj_q;
  logic perr_q;
  logic arr_rpar;
  logic wpar;

  assign wpar = even_parity(64'(wdata_q)) ^ inj_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         inj_q <= 1'b0;
    else if (accept) inj_q <= bus.parity_inj;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= last_cycle && !wr_cmd_q && !oob &&
                       (even_parity(64'(arr_rdata)) != arr_rpar);
  end

  assign bus.parity_err = perr_q;
`else
  logic unused_parity_inj;
  assign unused_parity_inj = bus.parity_inj;
  assign bus.parity_err    = 1'b0;
`endif

  data_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
`ifdef DATA_MEM_PARITY_EN
    .wpar_i  (wpar),
    .rpar_o  (arr_rpar),
`endif
    .rdata_o (arr_rdata)
  );

  assign bus.read_data = rdata_q;
  assign bus.busy_wait = busy;
  assign bus.err       = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_data_mem_lat.sv
module tb_data_mem_lat;
  import data_mem_pkg::*;

  localparam int L = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_lat_if #(.DATA_W(8), .ADDR_W(8)) bus0 ();
  data_mem_lat_if #(.DATA_W(8), .ADDR_W(8)) bus1 ();
  state_e st0, st1;

  // Unit 0: default DEPTH=256; unit 1: DEPTH=200 for range checks.
  data_mem_lat #(.DEPTH(256)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave), .state_o(st0));
  data_mem_lat #(.DEPTH(200)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave), .state_o(st1));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int u, input bit rd, input bit wr,
                       input logic [7:0] a, input logic [7:0] d, input bit inj);
    if (u == 0) begin
      bus0.read = rd; bus0.write = wr; bus0.address = a;
      bus0.write_data = d; bus0.parity_inj = inj;
    end else begin
      bus1.read = rd; bus1.write = wr; bus1.address = a;
      bus1.write_data = d; bus1.parity_inj = inj;
    end
  endtask

  task automatic set_addr(input int u, input logic [7:0] a);
    if (u == 0) bus0.address = a;
    else        bus1.address = a;
  endtask

  function automatic logic get_busy(input int u);
    return (u == 0) ? bus0.busy_wait : bus1.busy_wait;
  endfunction

  // Issue one access, count busy cycles, capture outputs in the first
  // non-busy cycle, then drop the request. chg_at>0 moves the address
  // to chg_a after that many busy cycles.
  task automatic do_access(input int u, input bit rd, input bit wr,
                           input logic [7:0] a, input logic [7:0] d, input bit inj,
                           input int chg_at, input logic [7:0] chg_a,
                           output int bcnt, output logic [7:0] rdv,
                           output logic e, output logic pe);
    @(posedge clk); #1;
    drive(u, rd, wr, a, d, inj);
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!get_busy(u)) break;
      bcnt++;
      if (bcnt == chg_at) begin #1; set_addr(u, chg_a); end
    end
    check("access_completes", 32'(get_busy(u)), 32'd0);
    rdv = (u == 0) ? bus0.read_data  : bus1.read_data;
    e   = (u == 0) ? bus0.err        : bus1.err;
    pe  = (u == 0) ? bus0.parity_err : bus1.parity_err;
    @(posedge clk); #1;
    drive(u, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  // ---------------- behavioural model + compare ----------------
  // Timestamp view: an access accepted in cycle s keeps busy_wait high
  // for cycles s..s+L and completes (DONE) in cycle s+L+1.
  logic [7:0] m_mem [2][256];
  logic       m_par [2][256];
  bit         m_on   [2];
  int         m_start[2];
  bit         m_wr   [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_data [2];
  bit         m_inj  [2];
  logic [7:0] m_rd   [2];
  bit         m_conf [2];
  int         depth_m[2] = '{256, 200};

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      automatic logic       i_rd = (u == 0) ? bus0.read       : bus1.read;
      automatic logic       i_wr = (u == 0) ? bus0.write      : bus1.write;
      automatic logic [7:0] i_a  = (u == 0) ? bus0.address    : bus1.address;
      automatic logic [7:0] i_d  = (u == 0) ? bus0.write_data : bus1.write_data;
      automatic logic       i_in = (u == 0) ? bus0.parity_inj : bus1.parity_inj;
      automatic logic       o_b  = (u == 0) ? bus0.busy_wait  : bus1.busy_wait;
      automatic logic [7:0] o_r  = (u == 0) ? bus0.read_data  : bus1.read_data;
      automatic logic       o_e  = (u == 0) ? bus0.err        : bus1.err;
      automatic logic       o_p  = (u == 0) ? bus0.parity_err : bus1.parity_err;
      automatic bit e_b, e_e, e_p, done;
      if (rst) begin
        for (int k = 0; k < 256; k++) begin m_mem[u][k] = 8'h00; m_par[u][k] = 1'b0; end
        m_on[u] = 0; m_rd[u] = 8'h00; m_conf[u] = 0;
        check("rst_busy", 32'(o_b), 32'd0);
        check("rst_read_data", 32'(o_r), 32'd0);
        check("rst_err", 32'(o_e), 32'd0);
        check("rst_parity_err", 32'(o_p), 32'd0);
      end else begin
        e_e = m_conf[u]; e_p = 0; done = 0;
        if (m_on[u] && cyc == m_start[u] + L + 1) begin
          done = 1; m_on[u] = 0;
          if (int'(m_addr[u]) >= depth_m[u]) begin
            e_e = 1;
            if (!m_wr[u]) m_rd[u] = 8'h00;
          end else if (m_wr[u]) begin
            m_mem[u][m_addr[u]] = m_data[u];
            m_par[u][m_addr[u]] = (^m_data[u]) ^ m_inj[u];
          end else begin
            m_rd[u] = m_mem[u][m_addr[u]];
`ifdef DATA_MEM_PARITY_EN
            e_p = (^m_mem[u][m_addr[u]]) != m_par[u][m_addr[u]];
`endif
          end
        end
        e_b = m_on[u] ? 1'b1 : (done ? 1'b0 : (i_rd ^ i_wr));
        check($sformatf("cyc_busy_u%0d", u), 32'(o_b), 32'(e_b));
        check($sformatf("cyc_read_data_u%0d", u), 32'(o_r), 32'(m_rd[u]));
        check($sformatf("cyc_err_u%0d", u), 32'(o_e), 32'(e_e));
        check($sformatf("cyc_parity_err_u%0d", u), 32'(o_p), 32'(e_p));
        m_conf[u] = !m_on[u] && !done && i_rd && i_wr;
        if (!m_on[u] && !done && (i_rd ^ i_wr)) begin
          m_on[u] = 1; m_start[u] = cyc;
          m_wr[u] = i_wr; m_addr[u] = i_a; m_data[u] = i_d; m_inj[u] = i_in;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int bc;
    logic [7:0] r;
    logic e, pe;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state_u0", 32'(st0), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_state_u0", 32'(st0), 32'(IDLE));
    check("post_rst_busy_u0", 32'(bus0.busy_wait), 32'd0);

    // 1: write 17 to addr 4, read back
    do_access(0, 0, 1, 8'd4, 8'd17, 0, 0, 8'd0, bc, r, e, pe);
    check("t1_write_busy_cycles", 32'(bc), 32'd11);
    exp_q.push_back(8'd17);
    do_access(0, 1, 0, 8'd4, 8'd0, 0, 0, 8'd0, bc, r, e, pe);
    check("t1_read_busy_cycles", 32'(bc), 32'd11);
    check("t1_read_data", 32'(r), 32'(exp_q.pop_front()));
    check("t1_read_err", 32'(e), 32'd0);

    // 2: read of never-written addr; reset in the middle of a write
    do_access(0, 1, 0, 8'd9, 8'd0, 0, 0, 8'd0, bc, r, e, pe);
    check("t2_read_data_zero", 32'(r), 32'd0);
    check("t2_read_err", 32'(e), 32'd0);
    @(posedge clk); #1;
    drive(0, 0, 1, 8'd3, 8'hAA, 0);
    repeat (6) @(negedge clk);
    check("t2_busy_before_rst", 32'(bus0.busy_wait), 32'd1);
    #1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #1;
    check("t2_busy_after_rst", 32'(bus0.busy_wait), 32'd0);
    check("t2_state_after_rst", 32'(st0), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    do_access(0, 1, 0, 8'd3, 8'd0, 0, 0, 8'd0, bc, r, e, pe);
    check("t2_lost_write", 32'(r), 32'd0);

    // 3: read and write together
    @(posedge clk); #1;
    drive(0, 1, 1, 8'd5, 8'h33, 0);
    @(negedge clk);
    check("t3_busy_conflict", 32'(bus0.busy_wait), 32'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    check("t3_err_pulse", 32'(bus0.err), 32'd1);
    check("t3_state_idle", 32'(st0), 32'(IDLE));
    @(negedge clk);
    check("t3_err_cleared", 32'(bus0.err), 32'd0);
    do_access(0, 1, 0, 8'd5, 8'd0, 0, 0, 8'd0, bc, r, e, pe);
    check("t3_mem_unchanged", 32'(r), 32'd0);

    // 4: out-of-range on DEPTH=200 unit, plus in-range boundaries
    do_access(1, 0, 1, 8'd210, 8'h55, 0, 0, 8'd0, bc, r, e, pe);
    check("t4_oob_write_err", 32'(e), 32'd1);
    check("t4_oob_write_busy", 32'(bc), 32'd11);
    do_access(1, 1, 0, 8'd210, 8'd0, 0, 0, 8'd0, bc, r, e, pe);
    check("t4_oob_read_data", 32'(r), 32'd0);
    check("t4_oob_read_err", 32'(e), 32'd1);
    check("t4_oob_read_busy", 32'(bc), 32'd11);
    do_access(1, 0, 1, 8'd199, 8'h66, 0, 0, 8'd0, bc, r, e, pe);
    check("t4_edge_write_err", 32'(e), 32'd0);
    do_access(1, 1, 0, 8'd199, 8'd0, 0, 0, 8'd0, bc, r, e, pe);
    check("t4_edge_read_data", 32'(r), 32'h66);
    do_access(0, 0, 1, 8'd210, 8'h3C, 0, 0, 8'd0, bc, r, e, pe);
    do_access(0, 1, 0, 8'd210, 8'd0, 0, 0, 8'd0, bc, r, e, pe);
    check("t4_full_depth_read", 32'(r), 32'h3C);
    check("t4_full_depth_err", 32'(e), 32'd0);

    // 5: held request and mid-access address change
    do_access(0, 0, 1, 8'd1, 8'h11, 0, 3, 8'd2, bc, r, e, pe);
    check("t5_busy_cycles", 32'(bc), 32'd11);
    @(negedge clk);
    check("t5_no_retrigger", 32'(bus0.busy_wait), 32'd0);
    do_access(0, 1, 0, 8'd2, 8'd0, 0, 0, 8'd0, bc, r, e, pe);
    check("t5_addr2_untouched", 32'(r), 32'd0);
    do_access(0, 1, 0, 8'd1, 8'd0, 0, 0, 8'd0, bc, r, e, pe);
    check("t5_addr1_written", 32'(r), 32'h11);

    // 6: parity
    do_access(0, 0, 1, 8'd6, 8'h07, 1, 0, 8'd0, bc, r, e, pe);
    do_access(0, 1, 0, 8'd6, 8'd0, 0, 0, 8'd0, bc, r, e, pe);
    check("t6_inj_read_data", 32'(r), 32'h07);
`ifdef DATA_MEM_PARITY_EN
    check("t6_inj_parity_err", 32'(pe), 32'd1);
`else
    check("t6_parity_err_off", 32'(pe), 32'd0);
`endif
    do_access(0, 0, 1, 8'd6, 8'h07, 0, 0, 8'd0, bc, r, e, pe);
    do_access(0, 1, 0, 8'd6, 8'd0, 0, 0, 8'd0, bc, r, e, pe);
    check("t6_clean_read_data", 32'(r), 32'h07);
    check("t6_clean_parity_err", 32'(pe), 32'd0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_lat.md
Name: data_mem_lat

Overview:
Parametrised single-port data memory with a configurable access latency and a busy_wait stall handshake toward the CPU core. It replaces the fixed 256x8, fixed-delay data memory and sits between the control unit / ALU and the register-file write-back mux. Address, data and command are latched when a request is accepted. It also adds range and command-conflict checking, and optional parity protection.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 8, address width in bits
DEPTH, 256, number of words; must be <= 2**ADDR_W
LATENCY, 10, clk cycles from request acceptance to access completion; minimum 1

Ports:
clk  in  1  clock, all state changes on posedge
rst  in  1  reset, asynchronous, active-high
read  in  1  read request, level
write  in  1  write request, level
address  in  ADDR_W  word address
write_data  in  DATA_W  write data
parity_inj  in  1  corrupt stored parity on the accepted write; ignored unless the optional feature is compiled in
read_data  out  DATA_W  registered read result, held until the next completed read
busy_wait  out  1  stall to PC and register file
err  out  1  one-cycle error pulse
parity_err  out  1  one-cycle parity mismatch pulse; constant 0 unless the optional feature is compiled in

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, counter=0, all words=0.
  - read_data=0, err=0, parity_err=0, busy_wait=0.
  - Any in-flight access is dropped; a pending write is not committed.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Valid request = read XOR write.
  - busy_wait is combinational: 1 whenever a valid request is present in IDLE, so the core stalls in the same cycle.
  - On posedge with a valid request: latch command, address and write_data; set counter=LATENCY-1; go to BUSY.
  - read=write=1: no access, err pulses 1 cycle, busy_wait stays 0, state remains IDLE.
- BUSY:
  - busy_wait=1.
  - Each posedge with counter!=0: counter decrements.
  - Posedge with counter==0: perform the access and go to DONE.
    - Write: mem[addr]<=data.
    - Read: read_data<=mem[addr].
  - Changes on read, write, address or write_data during BUSY are ignored.
- DONE:
  - busy_wait=0; lasts exactly one cycle; always returns to IDLE.
  - Requests present during DONE are ignored, so a still-asserted command from the stalled instruction cannot re-trigger.
- Latency: busy_wait is high for LATENCY+1 consecutive cycles per access; the result is visible from the DONE cycle.
- Out of range (latched addr >= DEPTH):
  - Access is performed as a no-op: write discarded, read_data<=0.
  - err pulses in the DONE cycle.
  - Timing is identical to a normal access.
- Width: addresses are not wrapped or truncated; comparison against DEPTH uses the full ADDR_W.
- Reset mid-BUSY: the write is lost, no err pulse, and the FSM is in IDLE on rst release.

Optional Feature:
DATA_MEM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit (^data) on write; if parity_inj=1 when the write is accepted, the inverted bit is stored.
  - Reads recompute parity; on mismatch, parity_err pulses in the DONE cycle. read_data still returns the stored data.
  - Reset clears parity bits to 0, which is consistent with zero data.
- Undefined: no parity storage, parity_inj is ignored, parity_err is tied to 0.
- Port list is identical in both builds.

Decomposition:
- Package data_mem_pkg:
  - state enum (IDLE, BUSY, DONE);
  - default parameter constants (DATA_W, ADDR_W, DEPTH, LATENCY);
  - a parity function.
- Sub-module data_mem_array: storage with async clear, a synchronous write-enable port and a read port (plus the parity bit under the macro).
- FSM, counter and checks remain in data_mem_lat.

Test Plan:
Defaults throughout (DATA_W=8, DEPTH=256, LATENCY=10).
1. Write 17 to addr 4 → busy_wait high for 11 cycles, then low for 1 DONE cycle; a later read of addr 4 → read_data=17 in DONE, busy 11 cycles.
2. Read addr 9 after reset → read_data=0, err=0; apply rst at BUSY cycle 5 of a write of 0xAA to addr 3 → busy_wait=0 immediately, a later read of addr 3 returns 0.
3. read=write=1 in IDLE → err one-cycle pulse, busy_wait never rises, memory unchanged.
4. DEPTH=200, write 0x55 to addr 210 → err pulse in DONE; read addr 210 → read_data=0, err pulse; timing 11 busy cycles.
5. Write 0x11 to addr 1 and hold write=1 and address through DONE → exactly one access; change address to 2 mid-BUSY → only addr 1 is written.
6. With DATA_MEM_PARITY_EN: write 0x07 to addr 6 with parity_inj=1, then read → read_data=0x07, parity_err pulses; repeat with parity_inj=0 → no pulse. Without the macro → parity_err stays 0.
